id_ex_control_pipe: RTL and testbench

Next-generation decode control for the pipelined MIPS core. It decodes opcode/funct/rt into a control bundle and registers that bundle into the ID/EX pipeline register, honouring stall and flush. It adds branch variants and a syscall drain-and-handshake FSM. It sits between the decoder and the EX stage.

---
 rtl/id_ex_control_pipe.sv | 262 ++++++++++++++++++++++++++
 tb/tb_id_ex_control_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_control_pipe.sv
// ID/EX control pipeline register: decodes opcode/funct/rt into a control bundle, registers it
// under stall/flush, and sequences syscalls through a drain-then-handshake FSM.
module id_ex_control_pipe #(
  parameter int unsigned ALU_OP_W     = 4,
  parameter int unsigned BV_W         = 3,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_id_valid,
  input  logic [5:0]          i_opcode,
  input  logic [5:0]          i_funct,
  input  logic [4:0]          i_rt,
  input  logic [ALU_OP_W-1:0] i_alu_op_in,
  input  logic                i_ex_stall,
  input  logic                i_flush,
  input  logic                i_sys_ack,
  output logic                o_id_ready,
  output logic                o_ex_valid,
  output logic                o_ex_reg_write,
  output logic                o_ex_mem_to_reg,
  output logic                o_ex_mem_write,
  output logic                o_ex_mem_byte,
  output logic                o_ex_alu_src,
  output logic                o_ex_reg_dest,
  output logic                o_ex_link,
  output logic [ALU_OP_W-1:0] o_ex_alu_op,
  output logic [BV_W-1:0]     o_ex_branch_variant,
  output logic                o_sys_req,
  output logic                o_illegal
);

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpRegimm  = 6'h01;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpBlez    = 6'h06;
  localparam logic [5:0] OpBgtz    = 6'h07;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0a;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d;
  localparam logic [5:0] OpLui     = 6'h0f;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSw      = 6'h2b;

  localparam logic [5:0] FnJr      = 6'h08;
  localparam logic [5:0] FnJalr    = 6'h09;
  localparam logic [5:0] FnSyscall = 6'h0c;

  localparam logic [BV_W-1:0] BvNone     = BV_W'(0);
  localparam logic [BV_W-1:0] BvJump     = BV_W'(1);
  localparam logic [BV_W-1:0] BvJumpLink = BV_W'(2);
  localparam logic [BV_W-1:0] BvJumpReg  = BV_W'(3);
  localparam logic [BV_W-1:0] BvBeq      = BV_W'(4);
  localparam logic [BV_W-1:0] BvBne      = BV_W'(5);
  localparam logic [BV_W-1:0] BvLezGtz   = BV_W'(6);
  localparam logic [BV_W-1:0] BvLtzGez   = BV_W'(7);

  localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StSysReq
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_next;

  logic            w_legal;
  logic            w_is_syscall;
  logic            w_accept;
  logic            w_load;
  logic            w_reg_write;
  logic            w_mem_to_reg;
  logic            w_mem_write;
  logic            w_mem_byte;
  logic            w_alu_src;
  logic            w_reg_dest;
  logic            w_link;
  logic [BV_W-1:0] w_bv;

  logic                r_ex_valid;
  logic                r_reg_write;
  logic                r_mem_to_reg;
  logic                r_mem_write;
  logic                r_mem_byte;
  logic                r_alu_src;
  logic                r_reg_dest;
  logic                r_link;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [BV_W-1:0]     r_bv;
  logic                r_illegal;

  // Combinational decode of the instruction currently in ID.
  always_comb begin
    w_legal      = 1'b1;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_byte   = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_dest   = 1'b0;
    w_link       = 1'b0;
    w_bv         = BvNone;
    case (i_opcode)
      OpSpecial: begin
        w_reg_dest  = 1'b1;
        w_reg_write = (i_funct != FnJr) && (i_funct != FnSyscall);
        w_link      = (i_funct == FnJalr);
        if ((i_funct == FnJr) || (i_funct == FnJalr)) begin
          w_bv = BvJumpReg;
        end
      end
      OpRegimm: begin
        if ((i_rt == 5'd0) || (i_rt == 5'd1)) begin
          w_bv = BvLtzGez;
        end else begin
          w_legal = 1'b0;
        end
      end
      OpJ:   w_bv = BvJump;
      OpJal: begin
        w_bv        = BvJumpLink;
        w_reg_write = 1'b1;
        w_link      = 1'b1;
      end
      OpBeq:          w_bv = BvBeq;
      OpBne:          w_bv = BvBne;
      OpBlez, OpBgtz: w_bv = BvLezGtz;
      OpAddiu, OpSlti, OpAndi, OpOri, OpLui: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      OpLb: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_mem_byte   = 1'b1;
        w_alu_src    = 1'b1;
      end
      OpLw: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 1'b1;
      end
      OpSb: begin
        w_mem_write = 1'b1;
        w_mem_byte  = 1'b1;
        w_alu_src   = 1'b1;
      end
      OpSw: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_is_syscall = (i_opcode == OpSpecial) && (i_funct == FnSyscall);
  assign o_id_ready   = (r_state == StRun) && !i_ex_stall && !i_flush;
  assign w_accept     = i_id_valid && o_id_ready;
  assign w_load       = w_accept && w_legal && !w_is_syscall;

  // Syscall sequencing: drain older instructions, then hold the request until acknowledged.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StRun: begin
        if (w_accept && w_is_syscall) begin
          w_state_next = StDrain;
          w_cnt_next   = DrainLoad;
        end
      end
      StDrain: begin
        if (i_flush) begin
          w_state_next = StRun;
          w_cnt_next   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_next = StSysReq;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      StSysReq: begin
        if (i_sys_ack) begin
          w_state_next = StRun;
        end
      end
      default: begin
        w_state_next = StRun;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StRun;
      r_cnt        <= 4'd0;
      r_illegal    <= 1'b0;
      r_ex_valid   <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_byte   <= 1'b0;
      r_alu_src    <= 1'b0;
      r_reg_dest   <= 1'b0;
      r_link       <= 1'b0;
      r_alu_op     <= '0;
      r_bv         <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_illegal <= w_accept && !w_legal;
      if (i_flush || (!i_ex_stall && !w_load)) begin
        r_ex_valid   <= 1'b0;
        r_reg_write  <= 1'b0;
        r_mem_to_reg <= 1'b0;
        r_mem_write  <= 1'b0;
        r_mem_byte   <= 1'b0;
        r_alu_src    <= 1'b0;
        r_reg_dest   <= 1'b0;
        r_link       <= 1'b0;
        r_alu_op     <= '0;
        r_bv         <= '0;
      end else if (!i_ex_stall) begin
        r_ex_valid   <= 1'b1;
        r_reg_write  <= w_reg_write;
        r_mem_to_reg <= w_mem_to_reg;
        r_mem_write  <= w_mem_write;
        r_mem_byte   <= w_mem_byte;
        r_alu_src    <= w_alu_src;
        r_reg_dest   <= w_reg_dest;
        r_link       <= w_link;
        r_alu_op     <= i_alu_op_in;
        r_bv         <= w_bv;
      end
    end
  end

  assign o_ex_valid          = r_ex_valid;
  assign o_ex_reg_write      = r_reg_write;
  assign o_ex_mem_to_reg     = r_mem_to_reg;
  assign o_ex_mem_write      = r_mem_write;
  assign o_ex_mem_byte       = r_mem_byte;
  assign o_ex_alu_src        = r_alu_src;
  assign o_ex_reg_dest       = r_reg_dest;
  assign o_ex_link           = r_link;
  assign o_ex_alu_op         = r_alu_op;
  assign o_ex_branch_variant = r_bv;
  assign o_sys_req           = (r_state == StSysReq);
  assign o_illegal           = r_illegal;

endmodule

// File: tb/tb_id_ex_control_pipe.sv
// Scoreboard bench for id_ex_control_pipe: a cycle-level reference model pushes expected
// outputs per issued cycle; an independent monitor pops and compares.
module tb_id_ex_control_pipe;
  localparam int unsigned ALU_OP_W     = 4;
  localparam int unsigned BV_W         = 3;
  localparam int unsigned DRAIN_CYCLES = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          id_valid = 1'b0;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic [4:0]    rt = '0;
  logic [3:0]    alu_op_in = '0;
  logic          ex_stall = 1'b0;
  logic          flush = 1'b0;
  logic          sys_ack = 1'b0;
  logic          id_ready, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_byte;
  logic          ex_alu_src, ex_reg_dest, ex_link, sys_req, illegal;
  logic [3:0]    ex_alu_op;
  logic [2:0]    ex_branch_variant;

  id_ex_control_pipe #(
    .ALU_OP_W    (ALU_OP_W),
    .BV_W        (BV_W),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_id_valid         (id_valid),
    .i_opcode           (opcode),
    .i_funct            (funct),
    .i_rt               (rt),
    .i_alu_op_in        (alu_op_in),
    .i_ex_stall         (ex_stall),
    .i_flush            (flush),
    .i_sys_ack          (sys_ack),
    .o_id_ready         (id_ready),
    .o_ex_valid         (ex_valid),
    .o_ex_reg_write     (ex_reg_write),
    .o_ex_mem_to_reg    (ex_mem_to_reg),
    .o_ex_mem_write     (ex_mem_write),
    .o_ex_mem_byte      (ex_mem_byte),
    .o_ex_alu_src       (ex_alu_src),
    .o_ex_reg_dest      (ex_reg_dest),
    .o_ex_link          (ex_link),
    .o_ex_alu_op        (ex_alu_op),
    .o_ex_branch_variant(ex_branch_variant),
    .o_sys_req          (sys_req),
    .o_illegal          (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v, rw, m2r, mw, mb, as, rd, lk;
    logic [3:0] alu;
    logic [2:0] bv;
  } bundle_t;

  typedef struct packed {
    bundle_t b;
    logic    legal;
    logic    sys;
  } dec_t;

  typedef struct {
    logic [17:0] vec;
    int          idx;
  } item_t;

  item_t   sb_q[$];
  int      n_cmp = 0;
  int      n_bad = 0;

  // Reference model state: the ID/EX contents plus the syscall in flight, if any.
  bundle_t m_ex = '0;
  bit      m_sc_active = 0;
  int      m_req_edge = 0;
  int      m_edge = 0;

  function automatic dec_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [4:0] r);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (op)
      6'h00: begin
        d.b.rd = 1'b1;
        d.sys  = (fn == 6'h0c);
        d.b.rw = !(fn == 6'h08 || fn == 6'h0c);
        d.b.lk = (fn == 6'h09);
        if (fn == 6'h08 || fn == 6'h09) d.b.bv = 3'd3;
      end
      6'h01: if (r <= 5'd1) d.b.bv = 3'd7; else d.legal = 1'b0;
      6'h02: d.b.bv = 3'd1;
      6'h03: begin d.b.bv = 3'd2; d.b.rw = 1'b1; d.b.lk = 1'b1; end
      6'h04: d.b.bv = 3'd4;
      6'h05: d.b.bv = 3'd5;
      6'h06, 6'h07: d.b.bv = 3'd6;
      6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0f: begin d.b.rw = 1'b1; d.b.as = 1'b1; end
      6'h20: begin d.b.rw = 1'b1; d.b.m2r = 1'b1; d.b.mb = 1'b1; d.b.as = 1'b1; end
      6'h23: begin d.b.rw = 1'b1; d.b.m2r = 1'b1; d.b.as = 1'b1; end
      6'h28: begin d.b.mw = 1'b1; d.b.mb = 1'b1; d.b.as = 1'b1; end
      6'h2b: begin d.b.mw = 1'b1; d.b.as = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // Drive one cycle of inputs and push the expected {id_ready, ex bundle, sys_req, illegal}.
  task automatic step(input logic rst, input logic v, input logic [5:0] op,
                      input logic [5:0] fn, input logic [4:0] r, input logic [3:0] alu,
                      input logic st, input logic fl, input logic ack);
    dec_t  d;
    bit    ready, in_req, acc, sreq;
    logic  ill;
    item_t it;
    @(negedge clk);
    rst_n = rst; id_valid = v; opcode = op; funct = fn; rt = r; alu_op_in = alu;
    ex_stall = st; flush = fl; sys_ack = ack;
    ill = 1'b0;
    if (!rst) begin
      ready       = !st && !fl;
      m_ex        = '0;
      m_sc_active = 0;
    end else begin
      ready  = !m_sc_active && !st && !fl;
      in_req = m_sc_active && (m_edge > m_req_edge);
      d      = ref_decode(op, fn, r);
      d.b.v  = 1'b1;
      d.b.alu = alu;
      acc    = v && ready;
      ill    = acc && !d.legal;
      if (fl) m_ex = '0;
      else if (!st) m_ex = (acc && d.legal && !d.sys) ? d.b : '0;
      if (m_sc_active) begin
        if (in_req) begin
          if (ack) m_sc_active = 0;
        end else if (fl) begin
          m_sc_active = 0;
        end
      end else if (acc && d.sys) begin
        m_sc_active = 1;
        m_req_edge  = m_edge + int'(DRAIN_CYCLES) + 1;
      end
    end
    sreq   = m_sc_active && (m_edge >= m_req_edge);
    it.vec = {ready, m_ex, sreq, ill};
    it.idx = m_edge;
    sb_q.push_back(it);
    m_edge++;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r,
                       input logic st, input logic fl, input logic ack);
    step(1'b1, 1'b1, op, fn, r, 4'($urandom_range(0, 15)), st, fl, ack);
  endtask

  task automatic idle(input logic ack);
    step(1'b1, 1'b0, 6'h00, 6'h00, 5'd0, 4'd0, 1'b0, 1'b0, ack);
  endtask

  // Monitor: id_ready is sampled just before the edge, registered outputs just after it.
  initial begin
    logic  r_rdy;
    item_t it;
    logic [17:0] got;
    forever begin
      @(negedge clk);
      #4;
      r_rdy = id_ready;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        got = {r_rdy, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_byte,
               ex_alu_src, ex_reg_dest, ex_link, ex_alu_op, ex_branch_variant, sys_req, illegal};
        n_cmp++;
        if (got !== it.vec) begin
          n_bad++;
          $display("FAIL cycle %0d {rdy,v,rw,m2r,mw,mb,as,rd,lk,alu,bv,sreq,ill}: got %b required %b",
                   it.idx, got, it.vec);
        end
      end
    end
  end

  logic [5:0] op_tbl [20] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                              6'h07, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0f, 6'h20, 6'h23, 6'h28,
                              6'h2b, 6'h3f};
  logic [5:0] fn_tbl [6]  = '{6'h08, 6'h09, 6'h0c, 6'h20, 6'h21, 6'h2a};

  initial begin
    logic [5:0] op, fn;
    // Asynchronous reset check before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_byte, ex_alu_src,
         ex_reg_dest, ex_link, ex_alu_op, ex_branch_variant, sys_req, illegal} !== 17'd0) begin
      n_bad++;
      $display("FAIL async_reset: outputs got %b required all zero",
               {ex_valid, ex_alu_op, ex_branch_variant, sys_req, illegal});
    end
    step(1'b0, 1'b0, 6'h00, 6'h00, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 6'h00, 6'h00, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // ADDIU, LW, SB back to back.
    instr(6'h09, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    instr(6'h23, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    instr(6'h28, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    // BNE held behind a 3-cycle stall, then loads.
    instr(6'h09, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) instr(6'h05, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0);
    instr(6'h05, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    // Flush and stall together: flush wins, JAL not consumed, then loads.
    instr(6'h03, 6'h00, 5'd0, 1'b1, 1'b1, 1'b0);
    instr(6'h03, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    // JR and JALR.
    instr(6'h00, 6'h08, 5'd0, 1'b0, 1'b0, 1'b0);
    instr(6'h00, 6'h09, 5'd0, 1'b0, 1'b0, 1'b0);
    // SYSCALL: drain, request, early ack ignored, ack after 5 cycles.
    instr(6'h00, 6'h0c, 5'd0, 1'b0, 1'b0, 1'b0);
    instr(6'h09, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    instr(6'h09, 6'h00, 5'd0, 1'b0, 1'b0, 1'b1);
    repeat (2) instr(6'h09, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    instr(6'h09, 6'h00, 5'd0, 1'b0, 1'b1, 1'b0);
    instr(6'h09, 6'h00, 5'd0, 1'b0, 1'b0, 1'b1);
    instr(6'h09, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    // Illegal opcode, REGIMM variants.
    instr(6'h3f, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    instr(6'h01, 6'h00, 5'd1, 1'b0, 1'b0, 1'b0);
    instr(6'h01, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    instr(6'h01, 6'h00, 5'd2, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    // Flush during drain aborts the syscall.
    instr(6'h00, 6'h0c, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b0, 6'h00, 6'h00, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    repeat (3) idle(1'b0);
    // Reset while in the request state.
    instr(6'h00, 6'h0c, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (6) idle(1'b0);
    step(1'b0, 1'b0, 6'h00, 6'h00, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    instr(6'h0f, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tbl[$urandom_range(0, 19)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tbl[$urandom_range(0, 5)];
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 4) != 0), op, fn,
           5'($urandom_range(0, 3)), 4'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
    end
    idle(1'b0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
